// File: rtl/online_sd_to_binary.sv
// Radix-2 on-the-fly signed-digit to two's-complement converter using Q/QM registers.
// data_out_vld rises 1 cycle after the N-th digit is accepted; no digit is taken while a word waits for the consumer.
module online_sd_to_binary #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         asyn_reset,
    input  logic [1:0]   data_in,
    input  logic         data_in_vld,
    output logic         data_in_rdy,
    output logic [N:0]   data_out,
    output logic         data_out_err,
    output logic         data_out_vld,
    input  logic         data_out_rdy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [N:0]    q_q, q_d;
    logic [N:0]    qm_q, qm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          out_vld_q, out_vld_d;
    logic          in_rdy_q, in_rdy_d;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (data_in_vld) begin
                    // QM tracks Q-1 so a -1 digit only selects a register, no borrow ripple
                    case (data_in)
                        2'b10: begin
                            q_d  = {q_q[N-1:0], 1'b1};
                            qm_d = {q_q[N-1:0], 1'b0};
                        end
                        2'b01: begin
                            q_d  = {qm_q[N-1:0], 1'b1};
                            qm_d = {qm_q[N-1:0], 1'b0};
                        end
                        default: begin
                            q_d  = {q_q[N-1:0], 1'b0};
                            qm_d = {qm_q[N-1:0], 1'b1};
                        end
                    endcase
                    cnt_d = cnt_q + 1'b1;
                    err_d = err_q | (data_in == 2'b11);
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (data_out_rdy) begin
                    state_d = COLLECT;
                    q_d     = '0;
                    qm_d    = '1;
                    err_d   = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
        out_vld_d = (state_d == HOLD);
        in_rdy_d  = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q   <= COLLECT;
            q_q       <= '0;
            qm_q      <= '1;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            qm_q      <= qm_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            out_vld_q <= out_vld_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

    assign data_in_rdy  = in_rdy_q & ~asyn_reset;
    assign data_out_vld = out_vld_q;
    assign data_out     = q_q;
    assign data_out_err = err_q;

endmodule

// File: tb/tb_online_sd_to_binary.sv
// Randomized bench for online_sd_to_binary (N=4) against an integer Horner-sum reference.
module tb_online_sd_to_binary;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         asyn_reset;
    logic [1:0]   data_in;
    logic         data_in_vld;
    logic         data_in_rdy;
    logic [N:0]   data_out;
    logic         data_out_err;
    logic         data_out_vld;
    logic         data_out_rdy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;
    int exp_out = 0;

    online_sd_to_binary #(.N(N)) dut (
        .clk          (clk),
        .asyn_reset   (asyn_reset),
        .data_in      (data_in),
        .data_in_vld  (data_in_vld),
        .data_in_rdy  (data_in_rdy),
        .data_out     (data_out),
        .data_out_err (data_out_err),
        .data_out_vld (data_out_vld),
        .data_out_rdy (data_out_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!asyn_reset && data_out_vld && data_out_rdy) n_out <= n_out + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_digit(input logic [1:0] c);
        int t = 0;
        data_in     = c;
        data_in_vld = 1'b1;
        while (!data_in_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("in_rdy_timeout", 0, 1);
        @(negedge clk);
        data_in_vld = 1'b0;
        data_in     = 2'($urandom);
    endtask

    task automatic model(input logic [2*N-1:0] w, output logic [N:0] val, output logic err);
        int v = 0;
        logic [1:0] c;
        err = 1'b0;
        for (int j = 0; j < N; j++) begin
            c = w[2*(N-1-j) +: 2];
            v = 2 * v + ((c == 2'b10) ? 1 : (c == 2'b01) ? -1 : 0);
            if (c == 2'b11) err = 1'b1;
        end
        val = v[N:0];
    endtask

    task automatic run_word(input logic [2*N-1:0] w, input int gap, input int hold);
        logic [N:0] ev;
        logic       ee;
        model(w, ev, ee);
        for (int j = 0; j < N; j++) begin
            check("vld_early", {31'b0, data_out_vld}, 0);
            send_digit(w[2*(N-1-j) +: 2]);
            if (j < N - 1)
                for (int g = 0; g < gap; g++) begin
                    data_in = 2'($urandom);
                    @(negedge clk);
                end
        end
        check("vld_latency", {31'b0, data_out_vld}, 1);
        check("data_out", 32'(data_out), 32'(ev));
        check("data_err", {31'b0, data_out_err}, {31'b0, ee});
        check("in_rdy_hold", {31'b0, data_in_rdy}, 0);
        for (int h = 0; h < hold; h++) begin
            data_in_vld = 1'($urandom);
            @(negedge clk);
            check("stall_vld", {31'b0, data_out_vld}, 1);
            check("stall_data", 32'(data_out), 32'(ev));
            check("stall_in_rdy", {31'b0, data_in_rdy}, 0);
        end
        data_in_vld  = 1'b0;
        data_out_rdy = 1'b1;
        @(negedge clk);
        data_out_rdy = 1'b0;
        exp_out++;
        check("vld_fall", {31'b0, data_out_vld}, 0);
        check("in_rdy_back", {31'b0, data_in_rdy}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        asyn_reset   = 1'b1;
        data_in      = 2'b00;
        data_in_vld  = 1'b0;
        data_out_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_rdy", {31'b0, data_in_rdy}, 0);
        check("rst_out_vld", {31'b0, data_out_vld}, 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_err", {31'b0, data_out_err}, 0);
        asyn_reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", {31'b0, data_in_rdy}, 1);

        run_word(8'b10_00_01_10, 0, 0);
        run_word(8'b01_01_01_01, 0, 0);
        run_word(8'b00_00_00_00, 0, 0);
        run_word(8'b10_00_01_10, 0, 3);
        run_word(8'b10_10_10_10, 1, 0);

        // Partial word discarded by reset
        send_digit(2'b10);
        send_digit(2'b01);
        asyn_reset = 1'b1;
        @(negedge clk);
        check("midrst_in_rdy", {31'b0, data_in_rdy}, 0);
        asyn_reset = 1'b0;
        @(negedge clk);
        check("midrst_out_cnt", n_out, exp_out);
        run_word(8'b00_00_00_10, 0, 0);

        run_word(8'b10_11_00_01, 0, 0);
        run_word(8'b10_00_00_01, 0, 0);

        // Reset while a word is pending
        for (int j = 0; j < N; j++) send_digit(2'b10);
        check("hold_vld", {31'b0, data_out_vld}, 1);
        asyn_reset = 1'b1;
        @(negedge clk);
        check("holdrst_vld", {31'b0, data_out_vld}, 0);
        check("holdrst_in_rdy", {31'b0, data_in_rdy}, 0);
        asyn_reset = 1'b0;
        @(negedge clk);
        check("holdrst_data", 32'(data_out), 0);
        check("holdrst_in_rdy_back", {31'b0, data_in_rdy}, 1);

        for (int k = 0; k < 40; k++)
            run_word(8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));

        check("out_count", n_out, exp_out);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
